// File: rtl/rpn_sequencer_if.sv
// Token, stack and result signals between the RPN sequencer and its neighbours.
// The sequencer uses the slave view; the token source, stack and result sink use the master view.
interface rpn_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic             tok_stb;
  logic             tok_op;
  logic [WIDTH-1:0] tok_dat;
  logic             tok_ack;

  logic             stk_push_stb;
  logic [WIDTH-1:0] stk_push_dat;
  logic             stk_push_ack;
  logic             stk_pop_req;
  logic [WIDTH-1:0] stk_top_dat;

  logic             res_stb;
  logic [WIDTH-1:0] res_dat;
  logic             res_ack;

  logic             err_flg;
  logic [1:0]       err_code;
  logic [CW-1:0]    depth_cnt;

  modport master (
    output tok_stb, tok_op, tok_dat, stk_push_ack, stk_top_dat, res_ack,
    input  tok_ack, stk_push_stb, stk_push_dat, stk_pop_req,
           res_stb, res_dat, err_flg, err_code, depth_cnt
  );

  modport slave (
    input  tok_stb, tok_op, tok_dat, stk_push_ack, stk_top_dat, res_ack,
    output tok_ack, stk_push_stb, stk_push_dat, stk_pop_req,
           res_stb, res_dat, err_flg, err_code, depth_cnt
  );
endinterface

// File: rtl/rpn_sequencer.sv
// Reverse-Polish evaluation controller: pushes operands, pops/computes/pushes for
// operators, presents the top on EQ, and tracks stack depth and sticky errors itself.
module rpn_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  rpn_sequencer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_EQ  = 3'd3;
  localparam logic [2:0] OP_CLR = 3'd4;

  localparam logic [1:0] E_NONE    = 2'd0;
  localparam logic [1:0] E_UNDER   = 2'd1;
  localparam logic [1:0] E_OVER    = 2'd2;
  localparam logic [1:0] E_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_POP_B, S_POP_A, S_EXEC, S_PUSH, S_OUT, S_DRAIN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] push_dat_q, push_dat_d;
  logic [WIDTH-1:0] res_dat_q, res_dat_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic             tok_ack;
  logic             push_stb;
  logic             pop_req;
  logic             res_stb;
  logic [2:0]       tok_code;
  logic             is_clr;

  assign tok_code = bus.tok_dat[2:0];
  assign is_clr   = bus.tok_op && (tok_code == OP_CLR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      push_dat_q <= '0;
      res_dat_q  <= '0;
      op_q       <= OP_ADD;
      depth_q    <= '0;
      err_q      <= 1'b0;
      code_q     <= E_NONE;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      push_dat_q <= push_dat_d;
      res_dat_q  <= res_dat_d;
      op_q       <= op_d;
      depth_q    <= depth_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    push_dat_d = push_dat_q;
    res_dat_d  = res_dat_q;
    op_d       = op_q;
    depth_d    = depth_q;
    err_d      = err_q;
    code_d     = code_q;
    tok_ack    = 1'b0;
    push_stb   = 1'b0;
    pop_req    = 1'b0;
    res_stb    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.tok_stb) begin
          tok_ack = 1'b1;
          if (is_clr) begin
            if (depth_q == '0) begin
              err_d  = 1'b0;
              code_d = E_NONE;
            end else begin
              state_d = S_DRAIN;
            end
          end else if (err_q) begin
            // Sticky error: the token is consumed and the first code is kept.
            state_d = S_IDLE;
          end else if (!bus.tok_op) begin
            if (depth_q == CW'(DEPTH)) begin
              err_d  = 1'b1;
              code_d = E_OVER;
            end else begin
              push_dat_d = bus.tok_dat;
              state_d    = S_PUSH;
            end
          end else if (tok_code > OP_CLR) begin
            err_d  = 1'b1;
            code_d = E_ILLEGAL;
          end else if (tok_code == OP_EQ) begin
            if (depth_q == '0) begin
              err_d  = 1'b1;
              code_d = E_UNDER;
            end else begin
              op_d    = tok_code;
              state_d = S_POP_B;
            end
          end else if (depth_q < CW'(2)) begin
            err_d  = 1'b1;
            code_d = E_UNDER;
          end else begin
            op_d    = tok_code;
            state_d = S_POP_B;
          end
        end
      end

      S_POP_B: begin
        // The top is read before this cycle's pop takes effect at the edge.
        b_d     = bus.stk_top_dat;
        pop_req = 1'b1;
        depth_d = depth_q - CW'(1);
        if (op_q == OP_EQ) begin
          res_dat_d = bus.stk_top_dat;
          state_d   = S_OUT;
        end else begin
          state_d = S_POP_A;
        end
      end

      S_POP_A: begin
        a_d     = bus.stk_top_dat;
        pop_req = 1'b1;
        depth_d = depth_q - CW'(1);
        state_d = S_EXEC;
      end

      S_EXEC: begin
        case (op_q)
          OP_ADD:  push_dat_d = a_q + b_q;
          OP_SUB:  push_dat_d = a_q - b_q;
          default: push_dat_d = a_q * b_q;
        endcase
        state_d = S_PUSH;
      end

      S_PUSH: begin
        push_stb = 1'b1;
        if (bus.stk_push_ack) begin
          depth_d = depth_q + CW'(1);
          state_d = S_IDLE;
        end
      end

      S_OUT: begin
        res_stb = 1'b1;
        if (bus.res_ack) begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        pop_req = 1'b1;
        depth_d = depth_q - CW'(1);
        if (depth_q <= CW'(1)) begin
          err_d   = 1'b0;
          code_d  = E_NONE;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.tok_ack      = tok_ack;
  assign bus.stk_push_stb = push_stb;
  assign bus.stk_push_dat = push_dat_q;
  assign bus.stk_pop_req  = pop_req;
  assign bus.res_stb      = res_stb;
  assign bus.res_dat      = res_dat_q;
  assign bus.err_flg      = err_q;
  assign bus.err_code     = code_q;
  assign bus.depth_cnt    = depth_q;
endmodule

// File: tb/tb_rpn_sequencer.sv
// Self-checking bench for rpn_sequencer: directed token table, multi-cycle corner
// sequences, then random tokens compared against a queue-based RPN reference model.
module tb_rpn_sequencer;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 16;
  localparam int SETTLE = 24;

  localparam bit D = 1'b0;
  localparam bit O = 1'b1;
  localparam logic [31:0] ADD = 32'd0;
  localparam logic [31:0] SUB = 32'd1;
  localparam logic [31:0] MUL = 32'd2;
  localparam logic [31:0] EQ  = 32'd3;
  localparam logic [31:0] CLR = 32'd4;

  typedef struct {
    bit          op;
    logic [31:0] dat;
    int          exp_depth;
    int          exp_code;
    bit          has_res;
    logic [31:0] exp_res;
    int          exp_pops;
    int          exp_pushes;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rpn_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  rpn_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // Attached 16-entry stack: push has priority, ack is combinational while not full.
  logic [31:0] stk_mem [DEPTH];
  int          stk_cnt;
  logic        push_stall = 1'b0;
  bit          stall_en = 1'b0;

  assign bus.stk_push_ack = (stk_cnt != DEPTH) && !push_stall;
  assign bus.stk_top_dat  = (stk_cnt == 0) ? 32'd0 : stk_mem[stk_cnt-1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk_cnt <= 0;
    end else if (bus.stk_push_stb && bus.stk_push_ack) begin
      stk_mem[stk_cnt] <= bus.stk_push_dat;
      stk_cnt <= stk_cnt + 1;
    end else if (bus.stk_pop_req && stk_cnt != 0) begin
      stk_cnt <= stk_cnt - 1;
    end
  end

  always @(posedge clk) push_stall <= stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;

  // Activity monitor sampled mid-cycle.
  int          pop_cnt = 0;
  int          push_cnt = 0;
  int          overlap_cnt = 0;
  logic [31:0] res_q[$];

  always @(negedge clk) begin
    if (bus.stk_pop_req) pop_cnt <= pop_cnt + 1;
    if (bus.stk_push_stb && bus.stk_push_ack) push_cnt <= push_cnt + 1;
    if (bus.stk_pop_req && bus.stk_push_stb) overlap_cnt <= overlap_cnt + 1;
    if (bus.res_stb && bus.res_ack) res_q.push_back(bus.res_dat);
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_tok(input bit op, input logic [31:0] dat);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    bus.tok_stb = 1'b1;
    bus.tok_op  = op;
    bus.tok_dat = dat;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (bus.tok_ack) got = 1'b1;
    end
    check("tok_ack seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    bus.tok_stb = 1'b0;
  endtask

  task automatic check_state(input string tag, input int d, input int c,
                             input bit has_res, input logic [31:0] r);
    check({tag, " depth"}, 32'(bus.depth_cnt), d);
    check({tag, " err_code"}, 32'(bus.err_code), c);
    check({tag, " err_flg"}, 32'(bus.err_flg), 32'(c != 0));
    check({tag, " results"}, res_q.size(), has_res ? 32'd1 : 32'd0);
    if (has_res && res_q.size() > 0) check({tag, " res_dat"}, res_q[0], r);
    $display("txn %s: depth=%0d code=%0d results=%0d", tag, bus.depth_cnt, bus.err_code, res_q.size());
    res_q.delete();
  endtask

  function automatic vec_t v(input bit op, input logic [31:0] dat, input int d, input int c,
                             input bit hr, input logic [31:0] r, input int pops, input int pushes);
    vec_t x;
    x.op = op; x.dat = dat; x.exp_depth = d; x.exp_code = c;
    x.has_res = hr; x.exp_res = r; x.exp_pops = pops; x.exp_pushes = pushes;
    return x;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " tok_ack"}, 32'(bus.tok_ack), 32'd0);
    check({tag, " push_stb"}, 32'(bus.stk_push_stb), 32'd0);
    check({tag, " pop_req"}, 32'(bus.stk_pop_req), 32'd0);
    check({tag, " res_stb"}, 32'(bus.res_stb), 32'd0);
    check({tag, " push_dat"}, bus.stk_push_dat, 32'd0);
    check({tag, " res_dat"}, bus.res_dat, 32'd0);
    check({tag, " err_flg"}, 32'(bus.err_flg), 32'd0);
    check({tag, " err_code"}, 32'(bus.err_code), 32'd0);
    check({tag, " depth"}, 32'(bus.depth_cnt), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    int p0, q0;
    logic [31:0] mq[$];
    bit          m_err;
    int          m_code;

    bus.tok_stb = 1'b0;
    bus.tok_op  = 1'b0;
    bus.tok_dat = '0;
    bus.res_ack = 1'b1;

    vecs.push_back(v(D, 3,   1, 0, 0, 0, 0, 1));
    vecs.push_back(v(D, 4,   2, 0, 0, 0, 0, 1));
    vecs.push_back(v(O, ADD, 1, 0, 0, 0, 2, 1));
    vecs.push_back(v(O, EQ,  0, 0, 1, 7, 1, 0));
    vecs.push_back(v(D, 10,  1, 0, 0, 0, 0, 1));
    vecs.push_back(v(D, 3,   2, 0, 0, 0, 0, 1));
    vecs.push_back(v(O, SUB, 1, 0, 0, 0, 2, 1));
    vecs.push_back(v(D, 2,   2, 0, 0, 0, 0, 1));
    vecs.push_back(v(O, MUL, 1, 0, 0, 0, 2, 1));
    vecs.push_back(v(O, EQ,  0, 0, 1, 14, 1, 0));
    vecs.push_back(v(D, 0,   1, 0, 0, 0, 0, 1));
    vecs.push_back(v(D, 1,   2, 0, 0, 0, 0, 1));
    vecs.push_back(v(O, SUB, 1, 0, 0, 0, 2, 1));
    vecs.push_back(v(O, EQ,  0, 0, 1, 32'hFFFF_FFFF, 1, 0));
    vecs.push_back(v(O, ADD, 0, 1, 0, 0, 0, 0));
    vecs.push_back(v(O, 5,   0, 1, 0, 0, 0, 0));
    vecs.push_back(v(D, 9,   0, 1, 0, 0, 0, 0));
    vecs.push_back(v(O, CLR, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(O, 6,   0, 3, 0, 0, 0, 0));
    vecs.push_back(v(O, EQ,  0, 3, 0, 0, 0, 0));
    vecs.push_back(v(O, CLR, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(O, EQ,  0, 1, 0, 0, 0, 0));
    vecs.push_back(v(O, CLR, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(D, 1,   1, 0, 0, 0, 0, 1));
    vecs.push_back(v(D, 2,   2, 0, 0, 0, 0, 1));
    vecs.push_back(v(D, 3,   3, 0, 0, 0, 0, 1));
    vecs.push_back(v(O, CLR, 0, 0, 0, 0, 3, 0));
    vecs.push_back(v(D, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 1));
    vecs.push_back(v(D, 2,   2, 0, 0, 0, 0, 1));
    vecs.push_back(v(O, ADD, 1, 0, 0, 0, 2, 1));
    vecs.push_back(v(D, 32'h1_0000, 2, 0, 0, 0, 0, 1));
    vecs.push_back(v(D, 32'h1_0000, 3, 0, 0, 0, 0, 1));
    vecs.push_back(v(O, MUL, 2, 0, 0, 0, 2, 1));
    vecs.push_back(v(O, SUB, 1, 0, 0, 0, 2, 1));
    vecs.push_back(v(O, EQ,  0, 0, 1, 1, 1, 0));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // Directed token table.
    foreach (vecs[i]) begin
      p0 = pop_cnt;
      q0 = push_cnt;
      send_tok(vecs[i].op, vecs[i].dat);
      settle(SETTLE);
      check_state($sformatf("vec%0d", i), vecs[i].exp_depth, vecs[i].exp_code,
                  vecs[i].has_res, vecs[i].exp_res);
      check($sformatf("vec%0d pops", i), pop_cnt - p0, vecs[i].exp_pops);
      check($sformatf("vec%0d pushes", i), push_cnt - q0, vecs[i].exp_pushes);
    end

    // Arithmetic latency: pops at T+1/T+2, EXEC at T+3, push at T+4.
    send_tok(D, 5);
    send_tok(D, 6);
    send_tok(O, ADD);
    @(negedge clk); check("add pop T+1", 32'(bus.stk_pop_req), 32'd1);
    @(negedge clk); check("add pop T+2", 32'(bus.stk_pop_req), 32'd1);
    @(negedge clk); check("add exec quiet", 32'(bus.stk_pop_req | bus.stk_push_stb), 32'd0);
    @(negedge clk); check("add push T+4", 32'(bus.stk_push_stb), 32'd1);
    check("add push_dat", bus.stk_push_dat, 32'd11);
    settle(2);
    check_state("latency add", 1, 0, 0, 0);

    // Result stall: RES held, no token accepted while waiting.
    bus.res_ack = 1'b0;
    send_tok(O, EQ);
    @(negedge clk); check("eq pop T+1", 32'(bus.stk_pop_req), 32'd1);
    @(posedge clk); #1;
    bus.tok_stb = 1'b1; bus.tok_op = D; bus.tok_dat = 32'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d res_stb", i), 32'(bus.res_stb), 32'd1);
      check($sformatf("stall%0d res_dat", i), bus.res_dat, 32'd11);
      check($sformatf("stall%0d tok_ack", i), 32'(bus.tok_ack), 32'd0);
    end
    @(posedge clk); #1;
    bus.tok_stb = 1'b0;
    bus.res_ack = 1'b1;
    settle(3);
    check_state("eq stall", 0, 0, 1, 11);

    // CLR of three entries drains in three consecutive cycles.
    send_tok(D, 1); send_tok(D, 2); send_tok(D, 3);
    send_tok(O, CLR);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check($sformatf("drain pop%0d", i), 32'(bus.stk_pop_req), 32'd1);
    end
    @(negedge clk); check("drain done", 32'(bus.stk_pop_req), 32'd0);
    settle(1);
    check_state("drain3", 0, 0, 0, 0);

    // Overflow on the 17th operand, then a full drain.
    for (int i = 0; i < DEPTH; i++) send_tok(D, 32'(i * 3 + 1));
    settle(4);
    check_state("full", DEPTH, 0, 0, 0);
    q0 = push_cnt;
    send_tok(D, 32'hDEAD);
    settle(4);
    check_state("overflow", DEPTH, 2, 0, 0);
    check("overflow pushes", push_cnt - q0, 32'd0);
    p0 = pop_cnt;
    send_tok(O, CLR);
    settle(SETTLE);
    check_state("drain16", 0, 0, 0, 0);
    check("drain16 pops", pop_cnt - p0, DEPTH);

    // Reset during EXEC.
    send_tok(D, 8);
    send_tok(D, 9);
    send_tok(O, ADD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset exec");
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_q.delete();
    settle(2);
    send_tok(D, 5);
    settle(4);
    send_tok(O, EQ);
    settle(6);
    check_state("post reset", 0, 0, 1, 5);

    // Random tokens against a queue-based reference model.
    m_err = 1'b0;
    m_code = 0;
    stall_en = 1'b1;
    for (int t = 0; t < 150; t++) begin
      bit          op;
      logic [31:0] dat, av, bv, rv, er;
      bit          has;
      int          r;
      r = $urandom_range(0, 99);
      op = 1'b1;
      if (r < 55)      begin op = 1'b0; dat = (r < 30) ? 32'($urandom_range(0, 20)) : $urandom; end
      else if (r < 72) dat = 32'($urandom_range(0, 2));
      else if (r < 86) dat = EQ;
      else if (r < 93) dat = CLR;
      else             dat = 32'($urandom_range(5, 7));

      has = 1'b0;
      er = '0;
      if (op && dat == CLR) begin
        mq.delete(); m_err = 1'b0; m_code = 0;
      end else if (m_err) begin
        m_err = 1'b1;
      end else if (!op) begin
        if (mq.size() == DEPTH) begin m_err = 1'b1; m_code = 2; end
        else mq.push_back(dat);
      end else if (dat > CLR) begin
        m_err = 1'b1; m_code = 3;
      end else if (dat == EQ) begin
        if (mq.size() == 0) begin m_err = 1'b1; m_code = 1; end
        else begin has = 1'b1; er = mq.pop_back(); end
      end else if (mq.size() < 2) begin
        m_err = 1'b1; m_code = 1;
      end else begin
        bv = mq.pop_back();
        av = mq.pop_back();
        if (dat == ADD)      rv = av + bv;
        else if (dat == SUB) rv = av - bv;
        else                 rv = av * bv;
        mq.push_back(rv);
      end

      send_tok(op, dat);
      settle(SETTLE);
      check_state($sformatf("rnd%0d op=%0d dat=%h", t, op, dat), mq.size(), m_code, has, er);
    end
    stall_en = 1'b0;

    check("push/pop overlap cycles", overlap_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
